// File: rtl/logic_gate_pipe.sv
`default_nettype none
// =============================================================================
// Module  : logic_gate_pipe
// Brief   : NUM_IN-operand bitwise AND/OR/XOR/NAND/NOR/XNOR reducer with a
//           registered valid/ready output stage, transfer counter and error flag.
// Revision: 1.0 - initial release
// =============================================================================
module logic_gate_pipe #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [2:0]              in_op,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [2:0]              out_op,
   output logic                    op_err,
   input  logic                    err_clr,
   output logic [CNT_W-1:0]        xfer_cnt
);

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] red_and;
   logic [WIDTH-1:0] red_or;
   logic [WIDTH-1:0] red_xor;
   logic [WIDTH-1:0] func;
   logic             illegal;
   logic             accept;
   logic             drain;

   always_comb begin
      red_and = '1;
      red_or  = '0;
      red_xor = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         red_and = red_and & in_data[k*WIDTH +: WIDTH];
         red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
         red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
      end
   end

   // Codes 6 and 7 still produce a (zero) result so the stream never stalls.
   always_comb begin
      func    = '0;
      illegal = 1'b0;
      case (in_op)
         OP_AND:  func = red_and;
         OP_OR:   func = red_or;
         OP_XOR:  func = red_xor;
         OP_NAND: func = ~red_and;
         OP_NOR:  func = ~red_or;
         OP_XNOR: func = ~red_xor;
         default: illegal = 1'b1;
      endcase
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_op    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= func;
         out_op    <= in_op;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

   // A new illegal accept outranks a coincident clear request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_err <= 1'b0;
      end else if (accept && illegal) begin
         op_err <= 1'b1;
      end else if (err_clr) begin
         op_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (drain) begin
         xfer_cnt <= xfer_cnt + CNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// =============================================================================
// Module  : tb_logic_gate_pipe
// Brief   : Bench for logic_gate_pipe; three instances share one handshake stream.
// Revision: 1.0 - initial release
// =============================================================================
module tb_logic_gate_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  in_op;
   logic        out_ready;
   logic        err_clr;
   logic [15:0] da;
   logic [23:0] db;
   logic [1:0]  dc;

   logic        rdy  [3];
   logic        ov   [3];
   logic [2:0]  oop  [3];
   logic        oerr [3];
   logic [7:0]  odat_a, odat_b;
   logic        odat_c;
   logic [1:0]  cnt_a;
   logic [15:0] cnt_b, cnt_c;

   int n_vec = 0;
   int n_err = 0;

   // instance 0: W8/N2/C2, 1: W8/N3/C16, 2: W1/N2/C16
   int ww   [3] = '{8, 8, 1};
   int nn   [3] = '{2, 3, 2};
   int cmod [3] = '{4, 65536, 65536};

   logic        m_valid [3];
   logic [31:0] m_data  [3];
   logic [2:0]  m_op    [3];
   logic        m_err   [3];
   int          m_cnt   [3];

   always #5 clk = ~clk;

   logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(da), .in_op(in_op), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(odat_a), .out_op(oop[0]), .op_err(oerr[0]), .err_clr(err_clr),
      .xfer_cnt(cnt_a));

   logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(db), .in_op(in_op), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(odat_b), .out_op(oop[1]), .op_err(oerr[1]), .err_clr(err_clr),
      .xfer_cnt(cnt_b));

   logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .CNT_W(16)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(dc), .in_op(in_op), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(odat_c), .out_op(oop[2]), .op_err(oerr[2]), .err_clr(err_clr),
      .xfer_cnt(cnt_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Per bit: count the ones among the operands and decide from the count.
   function automatic logic [31:0] ref_fn(input logic [31:0] d, input int n, input int w,
                                          input logic [2:0] op);
      logic [31:0] r;
      int ones;
      r = '0;
      for (int b = 0; b < w; b++) begin
         ones = 0;
         for (int k = 0; k < n; k++) ones += int'(d[k*w+b]);
         case (op)
            3'd0:    r[b] = (ones == n);
            3'd1:    r[b] = (ones > 0);
            3'd2:    r[b] = (ones % 2 == 1);
            3'd3:    r[b] = (ones != n);
            3'd4:    r[b] = (ones == 0);
            3'd5:    r[b] = (ones % 2 == 0);
            default: r[b] = 1'b0;
         endcase
      end
      return r;
   endfunction

   function automatic logic [31:0] get_data(input int i);
      case (i)
         0:       return {24'b0, odat_a};
         1:       return {24'b0, odat_b};
         default: return {31'b0, odat_c};
      endcase
   endfunction

   function automatic logic [31:0] get_cnt(input int i);
      case (i)
         0:       return {30'b0, cnt_a};
         1:       return {16'b0, cnt_b};
         default: return {16'b0, cnt_c};
      endcase
   endfunction

   task automatic check_outputs();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("out_valid[%0d]", i), {31'b0, ov[i]}, {31'b0, m_valid[i]});
         chk($sformatf("out_data[%0d]", i), get_data(i), m_data[i]);
         chk($sformatf("out_op[%0d]", i), {29'b0, oop[i]}, {29'b0, m_op[i]});
         chk($sformatf("op_err[%0d]", i), {31'b0, oerr[i]}, {31'b0, m_err[i]});
         chk($sformatf("xfer_cnt[%0d]", i), get_cnt(i), 32'(m_cnt[i]));
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = 1'b0; m_data[i] = '0; m_op[i] = '0; m_err[i] = 1'b0; m_cnt[i] = 0;
      end
   endtask

   // Entered at posedge+1 with inputs already applied; returns at next posedge+1.
   task automatic step();
      logic [31:0] dv [3];
      logic        nv [3];
      logic [31:0] nd [3];
      logic [2:0]  no [3];
      logic        ne [3];
      int          nc [3];
      logic        er, acc;
      dv[0] = {16'b0, da}; dv[1] = {8'b0, db}; dv[2] = {30'b0, dc};
      #1;
      for (int i = 0; i < 3; i++) begin
         er = !m_valid[i] || out_ready;
         chk($sformatf("in_ready[%0d]", i), {31'b0, rdy[i]}, {31'b0, er});
         acc = in_valid && er;
         nv[i] = m_valid[i]; nd[i] = m_data[i]; no[i] = m_op[i];
         ne[i] = m_err[i];   nc[i] = m_cnt[i];
         if (m_valid[i] && out_ready) begin
            nv[i] = 1'b0;
            nc[i] = (m_cnt[i] + 1) % cmod[i];
         end
         if (acc) begin
            nv[i] = 1'b1;
            nd[i] = ref_fn(dv[i], nn[i], ww[i], in_op);
            no[i] = in_op;
         end
         if (err_clr) ne[i] = 1'b0;
         if (acc && in_op >= 3'd6) ne[i] = 1'b1;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = nv[i]; m_data[i] = nd[i]; m_op[i] = no[i];
         m_err[i] = ne[i];   m_cnt[i] = nc[i];
      end
      check_outputs();
   endtask

   task automatic drv(input logic v, input logic [2:0] op, input logic r, input logic clr,
                      input logic [15:0] a, input logic [23:0] b, input logic [1:0] c);
      in_valid = v; in_op = op; out_ready = r; err_clr = clr;
      da = a; db = b; dc = c;
      step();
   endtask

   initial begin
      logic [7:0]  exp_ops [6];
      logic [1:0]  tt_in   [4];
      logic        tt_out  [4];
      logic [7:0]  held;
      exp_ops = '{8'h0C, 8'h3F, 8'h33, 8'hF3, 8'hC0, 8'hCC};
      tt_in   = '{2'b00, 2'b01, 2'b11, 2'b10};
      tt_out  = '{1'b0, 1'b1, 1'b1, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; out_ready = 1'b0; err_clr = 1'b0;
      da = '0; db = '0; dc = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;

      // OR truth table on the one-bit instance
      for (int t = 0; t < 4; t++) begin
         drv(1'b1, 3'd1, 1'b1, 1'b0, 16'h1234, 24'h00F0F0, tt_in[t]);
         chk("tt_or", {31'b0, odat_c}, {31'b0, tt_out[t]});
      end
      drv(1'b0, 3'd0, 1'b1, 1'b0, 16'h0, 24'h0, 2'b00);
      chk("tt_cnt", {16'b0, cnt_c}, 32'd4);
      chk("wrap_cnt4", {30'b0, cnt_a}, 32'd0);

      for (int op = 0; op < 6; op++) begin
         drv(1'b1, 3'(op), 1'b1, 1'b0, 16'h3C0F, 24'h010FFF, 2'b01);
         chk($sformatf("ops_op%0d", op), {24'b0, odat_a}, {24'b0, exp_ops[op]});
         if (op == 0) chk("n3_and", {24'b0, odat_b}, 32'h01);
         if (op == 1) chk("wrap_cnt5", {30'b0, cnt_a}, 32'd1);
         if (op == 2) chk("n3_xor", {24'b0, odat_b}, 32'hF1);
      end

      // backpressure: changing inputs while stalled must be ignored
      drv(1'b1, 3'd2, 1'b1, 1'b0, 16'hA55A, 24'h123456, 2'b10);
      held = odat_a;
      for (int t = 0; t < 5; t++) begin
         drv(1'b1, 3'($urandom_range(0, 5)), 1'b0, 1'b0, 16'($urandom), 24'($urandom),
             2'($urandom));
         chk("bp_hold", {24'b0, odat_a}, {24'b0, held});
      end
      for (int t = 0; t < 4; t++)
         drv(1'b1, 3'($urandom_range(0, 5)), 1'b1, 1'b0, 16'($urandom), 24'($urandom),
             2'($urandom));
      drv(1'b0, 3'd0, 1'b1, 1'b0, 16'h0, 24'h0, 2'b00);

      // illegal op handling and error clear priority
      drv(1'b1, 3'd7, 1'b1, 1'b0, 16'hFFFF, 24'hFFFFFF, 2'b11);
      chk("ill_data", {24'b0, odat_a}, 32'h0);
      chk("ill_err", {31'b0, oerr[0]}, 32'd1);
      drv(1'b1, 3'd0, 1'b1, 1'b0, 16'hFFFF, 24'hFFFFFF, 2'b11);
      drv(1'b1, 3'd3, 1'b1, 1'b0, 16'h00FF, 24'h00FF00, 2'b01);
      chk("ill_sticky", {31'b0, oerr[1]}, 32'd1);
      drv(1'b0, 3'd0, 1'b1, 1'b1, 16'h0, 24'h0, 2'b00);
      chk("err_clr", {31'b0, oerr[0]}, 32'd0);
      drv(1'b1, 3'd6, 1'b1, 1'b1, 16'h1111, 24'h222222, 2'b01);
      chk("set_wins", {31'b0, oerr[2]}, 32'd1);
      drv(1'b0, 3'd0, 1'b1, 1'b0, 16'h0, 24'h0, 2'b00);

      // randomized traffic
      for (int t = 0; t < 300; t++)
         drv(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
             16'($urandom), 24'($urandom), 2'($urandom));

      // asynchronous reset with a result pending
      drv(1'b1, 3'd1, 1'b1, 1'b0, 16'h00F0, 24'h0F0F0F, 2'b01);
      drv(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 24'h0, 2'b00);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_outputs();
      chk("arst_valid", {31'b0, ov[0]}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drv(1'b1, 3'd5, 1'b1, 1'b0, 16'h0FF0, 24'h00FF0F, 2'b10);
      drv(1'b0, 3'd0, 1'b1, 1'b0, 16'h0, 24'h0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, pipelined successor to the single-bit two-input OR gate.
- Reduces NUM_IN operands of WIDTH bits each, bitwise, using a runtime-selected operation: AND, OR, XOR, NAND, NOR or XNOR.
- The result is registered behind a valid/ready handshake with full-throughput backpressure.
- Counts completed results and flags illegal op codes; used as the datapath logic unit feeding downstream stages.

Parameters:
- WIDTH, 8, bit width of each operand and of the result.
- NUM_IN, 2, number of operands reduced per transaction (>=2).
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  NUM_IN*WIDTH  operands; operand k occupies bits [k*WIDTH +: WIDTH].
- in_op  in  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 illegal.
- out_valid  out  1  result held in output register.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  registered result.
- out_op  out  3  op code that produced out_data.
- op_err  out  1  sticky illegal-op flag.
- err_clr  in  1  clears op_err.
- xfer_cnt  out  CNT_W  number of output handshakes completed.

Behaviour:
- Reset: asynchronous on rst_n low. out_valid=0, out_data=0, out_op=0, op_err=0, xfer_cnt=0; in_ready=1 once out_valid=0.
- in_ready = !out_valid || out_ready (combinational). No skid buffer.
- Accept: occurs when in_valid && in_ready at a rising edge. That edge loads out_data=f(in_data,in_op) and out_op=in_op, and sets out_valid=1. Latency is one cycle.
- Hold: while out_valid && !out_ready, out_data and out_op are held stable and in_ready=0.
- Drain: if out_valid && out_ready && !in_valid, then out_valid goes to 0 on the next edge.
- Back-to-back: if out_ready=1 and in_valid=1 every cycle, one result is produced per cycle.
- Function, per bit i:
  - AND = AND over all NUM_IN operands; OR = OR over all; XOR = parity over all.
  - NAND/NOR/XNOR = bitwise inversion of AND/OR/XOR.
- Illegal op (6/7) on an accepted transaction:
  - out_data=0, out_op=in_op, out_valid=1 (the result is still delivered).
  - op_err is set on the same edge.
- op_err clear: err_clr=1 clears op_err on the next edge. If an illegal op is accepted on the same edge, set wins and op_err stays 1.
- xfer_cnt: increments by 1 on each out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- Input legality: in_data/in_op changes while in_valid && !in_ready are legal and ignored. Only the value present at the accept edge is used.
- Reset mid-operation: a pending result is discarded, and xfer_cnt and op_err are cleared immediately on rst_n falling (no clock needed).

Test Plan:
- Truth table, WIDTH=1, NUM_IN=2, op=1: inputs (0,0),(1,0),(1,1),(0,1) applied with out_ready=1 -> out_data 0,1,1,1, each one cycle after accept; xfer_cnt=4.
- All ops, WIDTH=8, NUM_IN=2, operands 0x0F,0x3C, op 0..5 -> out_data 0x0C, 0x3F, 0x33, 0xF3, 0xC0, 0xCC.
- NUM_IN=3, WIDTH=8, operands 0xFF,0x0F,0x01:
  - op=2 -> 0xF1.
  - op=0 -> 0x01.
- Backpressure: hold out_ready=0 for 5 cycles after one accept -> in_ready=0, out_data stable, xfer_cnt unchanged. Then raise out_ready with in_valid=1 -> one transfer per cycle, no loss or duplication.
- Illegal op 7 -> out_data=0x00, op_err=1 and remains set across later legal ops.
  - Pulse err_clr -> op_err=0.
  - err_clr coincident with another op 6 accept -> op_err stays 1.
- Reset and wrap:
  - With CNT_W=2, do 5 transfers -> xfer_cnt=1.
  - Assert rst_n=0 while out_valid=1 -> out_valid, out_data, xfer_cnt, op_err go to 0 asynchronously.
